// File: rtl/adc_responder.sv
`default_nettype none
// ============================================================================
// Module      : adc_responder
// Description : Device end of a serial-ADC link (cs_n / sck / mosi / miso).
//               Decodes a start bit plus {SGL, ODD, MSBF} config bits on
//               mosi, latches one of two DATA_W-bit samples, then shifts a
//               null bit, the word MSB-first and (when MSBF=0) an LSB-first
//               tail back out on miso, one bit per sck falling edge.
//
// Ports       : clk        system clock, all logic on rising edge
//               rst_n      asynchronous active-low reset
//               cs_n       chip select from master, active-low
//               sck        serial clock from master, idle low
//               mosi       serial config bits from master
//               sample0    word returned when ODD=0
//               sample1    word returned when ODD=1
//               miso       serial data to master
//               busy       frame in progress (after start bit, cs_n low)
//               cfg_valid  one-clk pulse when config bits are complete
//               cfg        {SGL, ODD, MSBF} of the last decoded frame
//               frame_err  sticky short-frame flag, cleared by next start bit
//
// Revision    : 1.0 - initial release
// ============================================================================
module adc_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              sck,
    input  logic              mosi,
    input  logic [DATA_W-1:0] sample0,
    input  logic [DATA_W-1:0] sample1,
    output logic              miso,
    output logic              busy,
    output logic              cfg_valid,
    output logic [2:0]        cfg,
    output logic              frame_err
);

    localparam int c_CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_ZERO = '0;

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_WAIT_START = 3'd1;
    localparam logic [2:0] c_CFG        = 3'd2;
    localparam logic [2:0] c_NULLB      = 3'd3;
    localparam logic [2:0] c_MSB        = 3'd4;
    localparam logic [2:0] c_LSB        = 3'd5;
    localparam logic [2:0] c_DONE       = 3'd6;

    // ------------------------------------------------------------------
    // Input synchronizers. The cs_n chain resets to 0 (not to its idle
    // level of 1): if cs_n is still low when reset releases, no false
    // falling edge is produced, so the next frame needs a real cs_n fall.
    // A pin that is high at release only yields a rise strobe, which is
    // harmless in IDLE.
    // ------------------------------------------------------------------
    logic w_cs;
    logic w_sck;
    logic w_mosi;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] r_cs_sy;
            logic [SYNC_STAGES-1:0] r_sck_sy;
            logic [SYNC_STAGES-1:0] r_mosi_sy;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cs_sy   <= '0;
                    r_sck_sy  <= '0;
                    r_mosi_sy <= '0;
                end else begin
                    r_cs_sy   <= SYNC_STAGES'({r_cs_sy, cs_n});
                    r_sck_sy  <= SYNC_STAGES'({r_sck_sy, sck});
                    r_mosi_sy <= SYNC_STAGES'({r_mosi_sy, mosi});
                end
            end

            assign w_cs   = r_cs_sy[SYNC_STAGES-1];
            assign w_sck  = r_sck_sy[SYNC_STAGES-1];
            assign w_mosi = r_mosi_sy[SYNC_STAGES-1];
        end else begin : g_nosync
            assign w_cs   = cs_n;
            assign w_sck  = sck;
            assign w_mosi = mosi;
        end
    endgenerate

    // Edge register: strobes compare the synchronized level with its
    // previous-clk value.
    logic r_cs_d;
    logic r_sck_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_d  <= 1'b0;
            r_sck_d <= 1'b0;
        end else begin
            r_cs_d  <= w_cs;
            r_sck_d <= w_sck;
        end
    end

    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sck_rise;
    logic w_sck_fall;

    assign w_cs_fall  = ~w_cs & r_cs_d;
    assign w_cs_rise  = w_cs & ~r_cs_d;
    // sck edges only count while the synchronized chip select is low.
    assign w_sck_rise = w_sck & ~r_sck_d & ~w_cs;
    assign w_sck_fall = ~w_sck & r_sck_d & ~w_cs;

    // ------------------------------------------------------------------
    // Frame state machine with registered outputs.
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [1:0]         r_cfg_cnt;
    logic               r_sgl;
    logic               r_odd;
    logic               r_msbf;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_word;
    logic               r_miso;
    logic               r_busy;
    logic               r_cfg_valid;
    logic [2:0]         r_cfg;
    logic               r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cfg_cnt   <= 2'd0;
            r_sgl       <= 1'b0;
            r_odd       <= 1'b0;
            r_msbf      <= 1'b0;
            r_cnt       <= c_ZERO;
            r_word      <= '0;
            r_miso      <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_valid <= 1'b0;
            r_cfg       <= 3'b000;
            r_frame_err <= 1'b0;
        end else begin
            r_cfg_valid <= 1'b0;

            // Deselect overrides any sck edge strobed on the same clk.
            if (w_cs_rise) begin
                if (r_state == c_CFG || r_state == c_NULLB || r_state == c_MSB) begin
                    r_frame_err <= 1'b1;
                end
                r_state <= c_IDLE;
                r_miso  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_miso <= 1'b0;
                        r_busy <= 1'b0;
                        if (w_cs_fall) begin
                            r_state <= c_WAIT_START;
                        end
                    end

                    // Leading zeros before the start bit are skipped.
                    c_WAIT_START: begin
                        if (w_sck_rise && w_mosi) begin
                            r_state     <= c_CFG;
                            r_busy      <= 1'b1;
                            r_frame_err <= 1'b0;
                            r_cfg_cnt   <= 2'd0;
                            r_cnt       <= c_ZERO;
                        end
                    end

                    c_CFG: begin
                        if (w_sck_rise) begin
                            r_cfg_cnt <= r_cfg_cnt + 2'd1;
                            case (r_cfg_cnt)
                                2'd0:    r_sgl <= w_mosi;
                                2'd1:    r_odd <= w_mosi;
                                default: begin
                                    r_msbf      <= w_mosi;
                                    r_cfg       <= {r_sgl, r_odd, w_mosi};
                                    r_cfg_valid <= 1'b1;
                                    // Sample is frozen here for the rest of the frame.
                                    r_word      <= r_odd ? sample1 : sample0;
                                    r_state     <= c_NULLB;
                                end
                            endcase
                        end
                    end

                    c_NULLB: begin
                        if (w_sck_fall) begin
                            r_miso  <= 1'b0;
                            r_cnt   <= c_LAST;
                            r_state <= c_MSB;
                        end
                    end

                    c_MSB: begin
                        if (w_sck_fall) begin
                            r_miso <= r_word[r_cnt];
                            if (r_cnt == c_ZERO) begin
                                // LSB tail restarts at bit 1; bit 0 is not repeated.
                                r_cnt   <= c_ONE;
                                r_state <= r_msbf ? c_DONE : c_LSB;
                            end else begin
                                r_cnt <= r_cnt - c_ONE;
                            end
                        end
                    end

                    c_LSB: begin
                        if (w_sck_fall) begin
                            r_miso <= r_word[r_cnt];
                            if (r_cnt == c_LAST) begin
                                r_state <= c_DONE;
                            end else begin
                                r_cnt <= r_cnt + c_ONE;
                            end
                        end
                    end

                    c_DONE: begin
                        if (w_sck_fall) begin
                            r_miso <= 1'b0;
                        end
                    end

                    default: begin
                        r_state <= c_IDLE;
                        r_miso  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign miso      = r_miso;
    assign busy      = r_busy;
    assign cfg_valid = r_cfg_valid;
    assign cfg       = r_cfg;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire
